// File: rtl/guess_pkg.sv
// Shared types and helpers for the guess input conditioner: debounce state
// encoding, default debounce length and switch-word population helpers.
package guess_pkg;

    localparam int unsigned DB_CYCLES_DEFAULT = 32'd1000000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    function automatic logic [4:0] count_ones16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit is set; returns the highest set index otherwise.
    function automatic logic [3:0] onehot_index16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/guess_input_cond_if.sv
// Interfaces for the guess input conditioner: a raw-button/press-strobe link
// to each debouncer, and the conditioned guess result bus.
interface btn_if;
    logic btn_raw;
    logic press_stb;

    modport master (input btn_raw, output press_stb);
    modport slave  (output btn_raw, input press_stb);
endinterface

interface guess_input_cond_if;
    logic       center_pulse;
    logic       guess_valid;
    logic       guess_err;
    logic [3:0] guess_dig;
    logic       guess_repeat;

    modport master (output center_pulse, guess_valid, guess_err, guess_dig, guess_repeat);
    modport slave  (input  center_pulse, guess_valid, guess_err, guess_dig, guess_repeat);
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a press/release
// debounce FSM that emits a single registered strobe per accepted press.
module btn_debounce
    import guess_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    btn_if.master btn
);

    localparam int unsigned CNT_W = (DB_CYCLES > 32'd1) ? $clog2(DB_CYCLES) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'd1);

    logic            sync1_r;
    logic            sync2_r;
    db_state_t       state_r;
    db_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic            stb_r;
    logic            stb_s;

    // Two-stage synchronizer for the raw button
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn.btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // FSM state, debounce counter and strobe registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            stb_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            stb_r   <= stb_s;
        end
    end

    // Next-state logic; the counter only advances below its last value, so it saturates
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        stb_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync2_r) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_r) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = HELD;
                    stb_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            HELD: begin
                if (!sync2_r) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_r) begin
                    state_s = HELD;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign btn.press_stb = stb_r;

endmodule

// File: rtl/guess_input_cond.sv
// Guess input conditioner: debounces Center/Down, stabilizes the slide switches
// and turns each Down press into a validated one-hot digit guess or an error strobe.
module guess_input_cond
    import guess_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Center,
    input  logic        Down,
    input  logic [15:0] SW,
    output logic        center_pulse,
    output logic        guess_valid,
    output logic        guess_err,
    output logic [3:0]  guess_dig,
    output logic        guess_repeat
);

    localparam int unsigned CNT_W = (DB_CYCLES > 32'd1) ? $clog2(DB_CYCLES) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'd1);

    btn_if center_if ();
    btn_if down_if ();

    assign center_if.btn_raw = Center;
    assign down_if.btn_raw   = Down;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_center_db (
        .CLK   (CLK),
        .RST_N (RST_N),
        .btn   (center_if)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_down_db (
        .CLK   (CLK),
        .RST_N (RST_N),
        .btn   (down_if)
    );

    logic [15:0]      sw_sync1_r;
    logic [15:0]      sw_sync2_r;
    logic [15:0]      sw_cand_r;
    logic [CNT_W-1:0] sw_cnt_r;
    logic [15:0]      sw_stable_r;

    logic [4:0]       ones_s;
    logic [3:0]       idx_s;
    logic             onehot_s;

    logic             center_pulse_r;
    logic             guess_valid_r;
    logic             guess_err_r;
    logic [3:0]       guess_dig_r;
    logic             guess_repeat_r;
    logic             no_prev_r;

    logic             guess_valid_s;
    logic             guess_err_s;
    logic [3:0]       guess_dig_s;
    logic             guess_repeat_s;
    logic             no_prev_s;

    // Two-stage synchronizer for the slide switches
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_sync1_r <= 16'h0000;
            sw_sync2_r <= 16'h0000;
        end else begin
            sw_sync1_r <= SW;
            sw_sync2_r <= sw_sync1_r;
        end
    end

    // Switch stabilizer: any change restarts the hold count, the count saturates at its last value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_cand_r   <= 16'h0000;
            sw_cnt_r    <= {CNT_W{1'b0}};
            sw_stable_r <= 16'h0000;
        end else if (sw_sync2_r != sw_cand_r) begin
            sw_cand_r <= sw_sync2_r;
            sw_cnt_r  <= {CNT_W{1'b0}};
        end else if (sw_cnt_r == CNT_LAST) begin
            sw_stable_r <= sw_cand_r;
        end else begin
            sw_cnt_r <= sw_cnt_r + CNT_W'(1'b1);
        end
    end

    assign ones_s   = count_ones16(sw_stable_r);
    assign idx_s    = onehot_index16(sw_stable_r);
    assign onehot_s = (ones_s == 5'd1);

    // Guess evaluation on the Down strobe; an illegal switch pattern leaves digit and repeat untouched
    always_comb begin
        guess_valid_s  = 1'b0;
        guess_err_s    = 1'b0;
        guess_dig_s    = guess_dig_r;
        guess_repeat_s = guess_repeat_r;
        no_prev_s      = no_prev_r;
        if (down_if.press_stb) begin
            if (onehot_s) begin
                guess_valid_s  = 1'b1;
                guess_dig_s    = idx_s;
                guess_repeat_s = !no_prev_r && (idx_s == guess_dig_r);
                no_prev_s      = 1'b0;
            end else begin
                guess_err_s = 1'b1;
            end
        end else begin
            guess_valid_s = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            center_pulse_r <= 1'b0;
            guess_valid_r  <= 1'b0;
            guess_err_r    <= 1'b0;
            guess_dig_r    <= 4'd0;
            guess_repeat_r <= 1'b0;
            no_prev_r      <= 1'b1;
        end else begin
            center_pulse_r <= center_if.press_stb;
            guess_valid_r  <= guess_valid_s;
            guess_err_r    <= guess_err_s;
            guess_dig_r    <= guess_dig_s;
            guess_repeat_r <= guess_repeat_s;
            no_prev_r      <= no_prev_s;
        end
    end

    assign center_pulse = center_pulse_r;
    assign guess_valid  = guess_valid_r;
    assign guess_err    = guess_err_r;
    assign guess_dig    = guess_dig_r;
    assign guess_repeat = guess_repeat_r;

endmodule

// File: tb/tb_guess_input_cond.sv
// Bench for guess_input_cond with DB_CYCLES=4: directed scenarios followed by
// randomized presses, every cycle compared against a timing-rule reference model.
module tb_guess_input_cond;

    localparam int DB = 4;
    localparam int STB_AT = DB + 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        Center;
    logic        Down;
    logic [15:0] SW;

    guess_input_cond_if gif ();

    guess_input_cond #(.DB_CYCLES(DB)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .Center       (Center),
        .Down         (Down),
        .SW           (SW),
        .center_pulse (gif.center_pulse),
        .guess_valid  (gif.guess_valid),
        .guess_err    (gif.guess_err),
        .guess_dig    (gif.guess_dig),
        .guess_repeat (gif.guess_repeat)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_dig;
    logic       m_rep;
    logic       m_have;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock; outputs compared at the following falling edge
    task automatic tick(input logic ec, input logic ev, input logic ee);
        @(posedge CLK);
        @(negedge CLK);
        chk("center_pulse", {3'd0, gif.center_pulse}, {3'd0, ec});
        chk("guess_valid",  {3'd0, gif.guess_valid},  {3'd0, ev});
        chk("guess_err",    {3'd0, gif.guess_err},    {3'd0, ee});
        chk("guess_dig",    gif.guess_dig,            m_dig);
        chk("guess_repeat", {3'd0, gif.guess_repeat}, {3'd0, m_rep});
    endtask

    // Reference rule for a debounced Down press against a settled switch word
    task automatic model_guess(input logic [15:0] sw, output logic ev, output logic ee);
        int n;
        int idx;
        n = 0;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (sw[i]) begin
                n++;
                idx = i;
            end
        end
        if (n == 1) begin
            m_rep  = m_have && (idx[3:0] == m_dig);
            m_dig  = idx[3:0];
            m_have = 1'b1;
            ev = 1'b1;
            ee = 1'b0;
        end else begin
            ev = 1'b0;
            ee = 1'b1;
        end
    endtask

    // Settle switches, then hold Center/Down high for the given number of clock edges
    task automatic run_press(input int c_len, input int d_len, input logic [15:0] sw);
        int   w;
        logic ec;
        logic ev;
        logic ee;
        SW = sw;
        repeat (DB + 8) tick(1'b0, 1'b0, 1'b0);
        w = (c_len > d_len) ? c_len : d_len;
        if (w < STB_AT) w = STB_AT;
        w = w + DB + 8;
        for (int j = 1; j <= w; j++) begin
            Center = (j <= c_len);
            Down   = (j <= d_len);
            ec = 1'b0;
            ev = 1'b0;
            ee = 1'b0;
            if (j == STB_AT) begin
                ec = (c_len >= DB + 1);
                if (d_len >= DB + 1) model_guess(sw, ev, ee);
            end
            tick(ec, ev, ee);
        end
    endtask

    initial begin
        int          c_len;
        int          d_len;
        int          kind;
        int          a;
        int          b;
        logic [15:0] sw_r;

        RST_N  = 1'b0;
        Center = 1'b0;
        Down   = 1'b0;
        SW     = 16'h0000;
        m_dig  = 4'd0;
        m_rep  = 1'b0;
        m_have = 1'b0;

        // Reset state
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;

        // Clean long press, legal one-hot: digit 5, first guess so no repeat
        run_press(0, 20, 16'h0020);
        // Short glitch: nothing happens
        run_press(0, 3, 16'h0020);
        // Two switches up: error, digit held
        run_press(0, 6, 16'h0021);
        // Same digit twice: repeat flagged on the second
        run_press(0, 6, 16'h8000);
        run_press(0, 6, 16'h8000);
        // Simultaneous Center and Down
        run_press(6, 6, 16'h0004);
        // No switches up: error
        run_press(0, 6, 16'h0000);

        // Reset two cycles into the press wait with Center held
        SW = 16'h0002;
        repeat (DB + 8) tick(1'b0, 1'b0, 1'b0);
        Center = 1'b1;
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        RST_N  = 1'b0;
        m_dig  = 4'd0;
        m_rep  = 1'b0;
        m_have = 1'b0;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(k == STB_AT, 1'b0, 1'b0);
        end
        Center = 1'b0;
        repeat (DB + 8) tick(1'b0, 1'b0, 1'b0);

        // First guess after reset matches the reset digit but must not be a repeat
        run_press(0, 6, 16'h0001);

        // Randomized presses and switch patterns
        for (int it = 0; it < 24; it++) begin
            c_len = $urandom_range(0, 9);
            d_len = $urandom_range(0, 9);
            kind  = $urandom_range(0, 3);
            a     = $urandom_range(0, 15);
            b     = (a + $urandom_range(1, 15)) % 16;
            sw_r  = 16'h0001;
            case (kind)
                0: sw_r = 16'h0000;
                1: sw_r = (sw_r << a) | (sw_r << b);
                2: sw_r = sw_r << a;
                default: sw_r = sw_r << m_dig;
            endcase
            run_press(c_len, d_len, sw_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/guess_input_cond.md
GUESS_INPUT_COND -- requirements
Module: guess_input_cond

Interface
REQ-001 The block SHALL have one parameter: DB_CYCLES, default 1000000 (10 ms at 100 MHz); debounce length in CLK cycles, minimum 2.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Center, input, 1 bit: raw asynchronous pushbutton (start/restart).
REQ-005 The block SHALL have port Down, input, 1 bit: raw asynchronous pushbutton (submit guess).
REQ-006 The block SHALL have port SW, input, 16 bits: raw asynchronous slide switches; bit i selects digit i.
REQ-007 The block SHALL have port center_pulse, output, 1 bit: one-cycle strobe per debounced Center press.
REQ-008 The block SHALL have port guess_valid, output, 1 bit: one-cycle strobe; guess_dig holds a legal new guess.
REQ-009 The block SHALL have port guess_err, output, 1 bit: one-cycle strobe; Down was pressed with zero or several switches up.
REQ-010 The block SHALL have port guess_dig, output, 4 bits: index of the single raised switch, held until the next guess_valid.
REQ-011 The block SHALL have port guess_repeat, output, 1 bit: qualifies guess_valid; guess_dig equals the previous accepted guess.

Function
REQ-012 Center, Down and each SW bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each button SHALL use a 4-state debounce FSM:
- IDLE: on sync=1, go to PRESS_WAIT and clear the counter.
- PRESS_WAIT: on sync=0, go to IDLE; when the count reaches DB_CYCLES-1, go to HELD and assert the press strobe.
- HELD: on sync=0, go to RELEASE_WAIT and clear the counter.
- RELEASE_WAIT: on sync=1, go to HELD with no strobe; when the count reaches DB_CYCLES-1, go to IDLE.
REQ-014 For a clean press held long enough, the press strobe SHALL be high exactly DB_CYCLES+3 cycles after the raw rising edge, for exactly 1 cycle.
REQ-015 A button held indefinitely SHALL produce exactly one strobe; glitches shorter than DB_CYCLES SHALL produce none, in either direction.
REQ-016 sw_stable (internal, 16 bits) SHALL load the synchronized SW only after that value has been unchanged for DB_CYCLES consecutive cycles; any change restarts the count.
REQ-017 On a Down strobe, the block SHALL evaluate sw_stable on the same cycle and register the result, so guess_valid/guess_err rise one cycle after the Down strobe.
REQ-018 If exactly one bit of sw_stable is set: guess_valid=1, guess_dig=that bit index, guess_repeat=(new index == previous accepted index).
REQ-019 If zero or two or more bits are set: guess_err=1, and guess_dig and guess_repeat are unchanged.
REQ-020 guess_valid and guess_err SHALL never be high together.
REQ-021 The first accepted guess after reset SHALL give guess_repeat=0.
REQ-022 center_pulse SHALL follow the Center debounce strobe, registered, with the same latency as guess_valid relative to its button.
REQ-023 Center and Down strobes SHALL be independent; simultaneous strobes SHALL both be reported in their own cycles.
REQ-024 Counters SHALL be sized $clog2(DB_CYCLES) and saturate; they SHALL never wrap.

Reset
REQ-025 While RST_N=0, the block SHALL force: both FSMs to IDLE, all counters to 0, synchronizers to 0, and sw_stable to 0.
REQ-026 While RST_N=0, the block SHALL force: center_pulse, guess_valid, guess_err and guess_repeat to 0, guess_dig to 0, and the "no previous guess" flag set.
REQ-027 Assertion of reset mid-debounce SHALL discard the partial count; after release, a still-held button SHALL need a full DB_CYCLES before it strobes.

Structure
REQ-028 A shared package guess_pkg SHALL hold the debounce state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the DB_CYCLES default constant.
REQ-029 A sub-module btn_debounce (synchronizer, FSM, counter, strobe output) SHALL be instantiated twice, for Center and Down.
REQ-030 The switch stabilizer and one-hot encoder SHALL live in the top module.

Verification (DB_CYCLES=4)
REQ-031 The bench SHALL cover each of the following scenarios:
- SW=16'h0020 stable, Down held 20 cycles -> one guess_valid with guess_dig=5 and guess_repeat=0, exactly 8 cycles after the Down edge.
- Down pulsed high for 3 cycles -> no strobes at all.
- SW=16'h0021, Down press -> guess_err=1 for 1 cycle, and guess_dig keeps its previous value.
- Two presses with SW=16'h8000 -> first gives guess_dig=15 and guess_repeat=0; second gives guess_repeat=1.
- Center and Down pressed on the same cycle -> center_pulse and the guess strobe each high for 1 cycle, in the same cycle.
- RST_N dropped 2 cycles into PRESS_WAIT, button kept held -> no strobe until DB_CYCLES+3 cycles after RST_N rises.
